// File: rtl/hdmi_pkg.sv
// Shared constants for the 640x480 DVI test-pattern source: video timing,
// TMDS control tokens, the clock-lane pattern and the colour-bar lookup.
package hdmi_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HSYNC_START = H_ACTIVE + H_FP;
  localparam int HSYNC_END   = HSYNC_START + H_SYNC;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VSYNC_START = V_ACTIVE + V_FP;
  localparam int VSYNC_END   = VSYNC_START + V_SYNC;

  localparam int BAR_WIDTH = H_ACTIVE / 8;

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  localparam logic [9:0] CLK_PATTERN = 10'b0000011111;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  // White, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_rgb(input logic [2:0] bar);
    rgb_t col;
    case (bar)
      3'd0:    col = rgb_t'(3'b111);
      3'd1:    col = rgb_t'(3'b110);
      3'd2:    col = rgb_t'(3'b011);
      3'd3:    col = rgb_t'(3'b010);
      3'd4:    col = rgb_t'(3'b101);
      3'd5:    col = rgb_t'(3'b100);
      3'd6:    col = rgb_t'(3'b001);
      default: col = rgb_t'(3'b000);
    endcase
    return col;
  endfunction

endpackage

// File: rtl/tmds_encoder_8b10b.sv
// DVI 8b/10b channel encoder: transition-minimising stage, DC balancing with
// a signed running disparity, and control tokens during blanking.
module tmds_encoder_8b10b
  import hdmi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              de,
  input  logic [DATA_W-1:0] d,
  input  logic [1:0]        c,
  output logic [DATA_W+1:0] q
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  function automatic logic [CNT_W-1:0] ones(input logic [DATA_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [DATA_W:0] min_transition(input logic [DATA_W-1:0] v,
                                                     input logic use_xnor);
    logic [DATA_W:0] m;
    m = '0;
    m[0] = v[0];
    for (int i = 1; i < DATA_W; i++)
      m[i] = use_xnor ? ~(m[i-1] ^ v[i]) : (m[i-1] ^ v[i]);
    m[DATA_W] = ~use_xnor;
    return m;
  endfunction

  function automatic logic [DATA_W+1:0] ctrl_token(input logic [1:0] cw);
    case (cw)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  logic [CNT_W-1:0]   n1_d, n1_q;
  logic               use_xnor;
  logic [DATA_W:0]    q_m;
  logic signed [5:0]  ones_minus_zeros;
  logic signed [5:0]  disp_p0, disp_nxt;
  logic [DATA_W+1:0]  q_nxt;

  assign n1_d     = ones(d);
  assign use_xnor = (n1_d > CNT_W'(DATA_W / 2)) ||
                    ((n1_d == CNT_W'(DATA_W / 2)) && !d[0]);
  assign q_m      = min_transition(d, use_xnor);
  assign n1_q     = ones(q_m[DATA_W-1:0]);
  assign ones_minus_zeros = $signed(6'({n1_q, 1'b0})) - $signed(6'(DATA_W));

  always_comb begin
    q_nxt    = '0;
    disp_nxt = disp_p0;
    if (!de) begin
      q_nxt    = ctrl_token(c);
      disp_nxt = 6'sd0;
    end else if (disp_p0 == 6'sd0 || ones_minus_zeros == 6'sd0) begin
      q_nxt    = {~q_m[DATA_W], q_m[DATA_W],
                  q_m[DATA_W] ? q_m[DATA_W-1:0] : ~q_m[DATA_W-1:0]};
      disp_nxt = q_m[DATA_W] ? disp_p0 + ones_minus_zeros
                             : disp_p0 - ones_minus_zeros;
    end else if ((disp_p0 > 6'sd0 && ones_minus_zeros > 6'sd0) ||
                 (disp_p0 < 6'sd0 && ones_minus_zeros < 6'sd0)) begin
      q_nxt    = {1'b1, q_m[DATA_W], ~q_m[DATA_W-1:0]};
      disp_nxt = disp_p0 + (q_m[DATA_W] ? 6'sd2 : 6'sd0) - ones_minus_zeros;
    end else begin
      q_nxt    = {1'b0, q_m[DATA_W], q_m[DATA_W-1:0]};
      disp_nxt = disp_p0 - (q_m[DATA_W] ? 6'sd0 : 6'sd2) + ones_minus_zeros;
    end
  end

  // Stage p0: symbol and disparity commit once per pixel.
  always_ff @(posedge clk) begin
    if (reset)   disp_p0 <= 6'sd0;
    else if (ce) disp_p0 <= disp_nxt;
  end

  always_ff @(posedge clk) begin
    if (ce) q <= q_nxt;
  end

endmodule

// File: rtl/hdmi_encoder.sv
// 640x480 colour-bar DVI source running on the TMDS bit clock: timing,
// pattern, three channel encoders and four 10:1 serialisers.
module hdmi_encoder
  import hdmi_pkg::*;
#(
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       DE,
  output logic [3:0] tmds
);

  localparam int V_TOT    = V_ACT + V_FRONT + V_SW + V_BACK;
  localparam int VS_START = V_ACT + V_FRONT;
  localparam int VS_END   = VS_START + V_SW;

  logic [3:0]       bit_cnt;
  logic             pix_ce, enc_ce;
  logic [9:0]       h_cnt, v_cnt;
  logic             active, hsync, vsync;
  logic [2:0]       bar;
  rgb_t             rgb;
  logic [9:0]       sym_b_p0, sym_g_p0, sym_r_p0;
  logic             vld_p0, vld_p1;
  logic [3:0][9:0]  sh_p1;

  // Encoders commit one clock before the serialisers load, so the symbol for
  // the current h_cnt is ready exactly at pix_ce.
  assign pix_ce = (bit_cnt == 4'd9);
  assign enc_ce = (bit_cnt == 4'd8);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      bit_cnt <= pix_ce ? 4'd0 : bit_cnt + 4'd1;
      if (pix_ce) begin
        if (h_cnt == 10'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'(V_TOT - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACT));
  assign hsync  = !((h_cnt >= 10'(HSYNC_START)) && (h_cnt < 10'(HSYNC_END)));
  assign vsync  = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));
  assign bar    = 3'(h_cnt / 10'(BAR_WIDTH));
  assign rgb    = bar_rgb(bar);

  // hsync is the upper control bit, so an hsync-only pulse emits 0x0AB.
  tmds_encoder_8b10b u_enc_b (
    .clk(clk), .reset(reset), .ce(enc_ce), .de(active),
    .d({8{rgb.b}}), .c({hsync, vsync}), .q(sym_b_p0)
  );

  tmds_encoder_8b10b u_enc_g (
    .clk(clk), .reset(reset), .ce(enc_ce), .de(active),
    .d({8{rgb.g}}), .c(2'b00), .q(sym_g_p0)
  );

  tmds_encoder_8b10b u_enc_r (
    .clk(clk), .reset(reset), .ce(enc_ce), .de(active),
    .d({8{rgb.r}}), .c(2'b00), .q(sym_r_p0)
  );

  always_ff @(posedge clk) begin
    if (reset)       vld_p0 <= 1'b0;
    else if (enc_ce) vld_p0 <= active;
  end

  // Stage p1: all four lanes load together and shift out LSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      sh_p1  <= '0;
    end else if (pix_ce) begin
      vld_p1 <= vld_p0;
      sh_p1  <= {CLK_PATTERN, sym_r_p0, sym_g_p0, sym_b_p0};
    end else begin
      for (int l = 0; l < 4; l++) sh_p1[l] <= {1'b0, sh_p1[l][9:1]};
    end
  end

  assign DE   = vld_p1;
  assign tmds = {sh_p1[3][0], sh_p1[2][0], sh_p1[1][0], sh_p1[0][0]};

endmodule

// File: tb/tb_hdmi_encoder.sv
// Scoreboard bench for hdmi_encoder with a shortened vertical frame so that
// full-frame wrap and sync behaviour fit in a short run.
module tb_hdmi_encoder;

  localparam int V_ACT   = 2;
  localparam int V_FRONT = 1;
  localparam int V_SW    = 1;
  localparam int V_BACK  = 1;
  localparam int V_TOT   = V_ACT + V_FRONT + V_SW + V_BACK;
  localparam int VS0     = V_ACT + V_FRONT;
  localparam int VS1     = VS0 + V_SW;
  localparam int H_TOT   = 800;
  localparam int FRAME_SLOTS = H_TOT * V_TOT;
  localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                      3'b101, 3'b100, 3'b001, 3'b000};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       de_o;
  logic [3:0] tmds;

  hdmi_encoder #(.V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_SW(V_SW), .V_BACK(V_BACK)) dut (
    .clk(clk), .reset(reset), .DE(de_o), .tmds(tmds)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic       de;
    logic [9:0] l0, l1, l2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cur_slot = -1;
  int   slot_done = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s slot=%0d got=%0h want=%0h", name, cur_slot, got, want);
    end
  endtask

  task automatic push(input int s, input logic de, input logic [9:0] a,
                      input logic [9:0] b, input logic [9:0] c);
    exp_q.push_back('{s, de, a, b, c});
  endtask

  function automatic logic [7:0] dvi_dec(input logic [9:0] sym);
    logic [7:0] t, d;
    t = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = t[0];
    for (int i = 1; i < 8; i++) d[i] = sym[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    return d;
  endfunction

  function automatic int ones10(input logic [9:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [9:0] token(input logic hs, input logic vs);
    if (hs && vs)  return 10'h2AB;
    if (!hs && vs) return 10'h0AB;
    if (hs && !vs) return 10'h154;
    return 10'h354;
  endfunction

  task automatic wait_slot(input int target, input int budget);
    int n = 0;
    while (slot_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    cur_slot = target;
    chk("wait_slot", 32'(slot_done >= target), 32'd1);
  endtask

  // Monitor: deserialise every 10-clock slot and compare.
  initial begin
    int k, b, s, h, v, de_clks;
    int disp [3];
    logic [9:0] sh [4];
    logic de_first, de_steady, act, hs, vs;
    logic [2:0] rgb;
    exp_t e;
    k = 0; de_clks = 0; de_first = 1'b0; de_steady = 1'b1;
    for (int i = 0; i < 3; i++) disp[i] = 0;
    for (int i = 0; i < 4; i++) sh[i] = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        k = 0; de_clks = 0; slot_done = -1;
        for (int i = 0; i < 3; i++) disp[i] = 0;
      end else begin
        k++;
      end
      @(negedge clk);
      if (de_o === 1'b1) de_clks++;
      if (k < 10) begin
        cur_slot = -1;
        chk("idle_tmds", 32'(tmds), 32'd0);
        chk("idle_de", 32'(de_o), 32'd0);
      end else begin
        b = (k - 10) % 10;
        s = (k - 10) / 10;
        for (int l = 0; l < 4; l++) sh[l][b] = tmds[l];
        if (b == 0) begin
          de_first = de_o; de_steady = 1'b1;
        end else if (de_o !== de_first) begin
          de_steady = 1'b0;
        end
        if (b == 9) begin
          cur_slot = s;
          h = s % H_TOT;
          v = (s / H_TOT) % V_TOT;
          act = (h < 640) && (v < V_ACT);
          chk("clk_lane", 32'(sh[3]), 32'h01F);
          chk("de_steady", 32'(de_steady), 32'd1);
          chk("de", 32'(de_first), 32'(act));
          if (act) begin
            rgb = BARS[h / 80];
            for (int ch = 0; ch < 3; ch++) begin
              chk($sformatf("pix_ch%0d", ch), 32'(dvi_dec(sh[ch])), rgb[ch] ? 32'hFF : 32'h00);
              disp[ch] += 2 * ones10(sh[ch]) - 10;
              chk($sformatf("disp_ch%0d", ch), 32'(disp[ch] >= -8 && disp[ch] <= 8), 32'd1);
            end
          end else begin
            hs = !(h >= 656 && h < 752);
            vs = !(v >= VS0 && v < VS1);
            chk("ctl_ch0", 32'(sh[0]), 32'(token(hs, vs)));
            chk("ctl_ch1", 32'(sh[1]), 32'h354);
            chk("ctl_ch2", 32'(sh[2]), 32'h354);
            for (int ch = 0; ch < 3; ch++) disp[ch] = 0;
          end
          if (s == FRAME_SLOTS - 1) chk("de_clocks_frame", 32'(de_clks), 32'(640 * V_ACT * 10));
          if (exp_q.size() > 0 && exp_q[0].slot == s) begin
            e = exp_q.pop_front();
            chk("sb_de", 32'(de_first), 32'(e.de));
            chk("sb_lane0", 32'(sh[0]), 32'(e.l0));
            chk("sb_lane1", 32'(sh[1]), 32'(e.l1));
            chk("sb_lane2", 32'(sh[2]), 32'(e.l2));
          end
          slot_done = s;
        end
      end
    end
  end

  // Stimulus: issue resets and post the hand-computed expectations.
  initial begin
    push(0,    1'b1, 10'h200, 10'h200, 10'h200);
    push(1,    1'b1, 10'h0FF, 10'h0FF, 10'h0FF);
    push(2,    1'b1, 10'h0FF, 10'h0FF, 10'h0FF);
    push(3,    1'b1, 10'h200, 10'h200, 10'h200);
    push(640,  1'b0, 10'h2AB, 10'h354, 10'h354);
    push(655,  1'b0, 10'h2AB, 10'h354, 10'h354);
    push(656,  1'b0, 10'h0AB, 10'h354, 10'h354);
    push(751,  1'b0, 10'h0AB, 10'h354, 10'h354);
    push(752,  1'b0, 10'h2AB, 10'h354, 10'h354);
    push(799,  1'b0, 10'h2AB, 10'h354, 10'h354);
    push(800,  1'b1, 10'h200, 10'h200, 10'h200);
    push(1600, 1'b0, 10'h2AB, 10'h354, 10'h354);
    push(2500, 1'b0, 10'h154, 10'h354, 10'h354);
    push(3100, 1'b0, 10'h354, 10'h354, 10'h354);
    push(3200, 1'b0, 10'h2AB, 10'h354, 10'h354);
    push(4000, 1'b1, 10'h200, 10'h200, 10'h200);
    push(4001, 1'b1, 10'h0FF, 10'h0FF, 10'h0FF);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_slot(FRAME_SLOTS + 1, FRAME_SLOTS * 10 + 200);
    wait_slot(4100, 1200);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    push(0, 1'b1, 10'h200, 10'h200, 10'h200);
    push(1, 1'b1, 10'h0FF, 10'h0FF, 10'h0FF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_slot(1, 300);
    cur_slot = -1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
